game_flow_controller: RTL and testbench

//  Central game sequencer in the clk_25MHz domain, between the player/ghost control blocks and the renderer/score display.

---
 rtl/game_flow_controller.sv | 173 +++++++++++++++++
 tb/tb_game_flow_controller.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_controller.sv
// Central game sequencer: game state, power-pellet countdown, dot counter, score and ghost respawn requests.
// Optional feature macro LIVES_EN adds a 3-life counter (o_lives, o_player_respawn).
module game_flow_controller #(
    parameter int MAX_DOTS      = 240,
    parameter int POWER_TICKS   = 40,
    parameter int DOT_POINTS    = 10,
    parameter int BIGDOT_POINTS = 50,
    parameter int GHOST_POINTS  = 200,
    parameter int SCORE_W       = 20
) (
    input  logic               clk_25MHz,
    input  logic               reset,
    input  logic               i_tick,
    input  logic               i_start_req,
    input  logic               i_dot_eaten,
    input  logic               i_big_dot_eaten,
    input  logic [3:0]         i_ghost_hit,
    output logic [2:0]         o_game_state,
    output logic               o_freeze,
    output logic [3:0]         o_ghost_respawn,
    output logic [SCORE_W-1:0] o_score,
    output logic [8:0]         o_dots_eaten,
    output logic [7:0]         o_power_remaining
`ifdef LIVES_EN
    ,
    output logic [1:0]         o_lives,
    output logic               o_player_respawn
`endif
);

    // state    | meaning
    // STANDBY  | waiting for a direction key, characters frozen
    // PLAYING  | normal play, any ghost contact is a collision
    // POWER    | power pellet active, ghosts can be eaten
    // GAMEOVER | terminal, only reset exits
    // WIN      | terminal, all dots eaten
    typedef enum logic [2:0] {
        ST_STANDBY  = 3'd0,
        ST_PLAYING  = 3'd1,
        ST_POWER    = 3'd2,
        ST_GAMEOVER = 3'd3,
        ST_WIN      = 3'd4
    } state_t;

    localparam logic [SCORE_W:0] SCORE_MAX = (SCORE_W+1)'(999999);
    localparam logic [8:0]       DOTS_MAX  = 9'(MAX_DOTS);

    state_t               r_state, w_state_n;
    logic [SCORE_W-1:0]   r_score, w_score_n;
    logic [8:0]           r_dots, w_dots_n;
    logic [7:0]           r_power, w_power_n;
    logic [3:0]           r_respawn, w_respawn_n;
    logic                 r_freeze, w_freeze_n;
    logic [3:0]           r_ghost_hit_d;
    logic [1:0]           r_lives, w_lives_n;
    logic                 r_player_respawn, w_player_respawn_n;

    logic [3:0]           w_rise;
    logic [11:0]          w_add;
    logic [SCORE_W:0]     w_score_sum;
    logic [9:0]           w_dots_sum;

    assign w_rise = i_ghost_hit & ~r_ghost_hit_d;

    // Ghost points only count while the pellet is active.
    always_comb begin
        w_add = (i_dot_eaten     ? 12'(DOT_POINTS)    : 12'd0)
              + (i_big_dot_eaten ? 12'(BIGDOT_POINTS) : 12'd0);
        if (r_state == ST_POWER)
            w_add = w_add + 12'(GHOST_POINTS) * 12'($countones(w_rise));
    end

    assign w_score_sum = {1'b0, r_score} + (SCORE_W+1)'(w_add);
    assign w_dots_sum  = {1'b0, r_dots} + 10'(i_dot_eaten) + 10'(i_big_dot_eaten);

    always_comb begin
        w_state_n          = r_state;
        w_score_n          = r_score;
        w_dots_n           = r_dots;
        w_power_n          = r_power;
        w_respawn_n        = 4'd0;
        w_lives_n          = r_lives;
        w_player_respawn_n = 1'b0;

        case (r_state)
            ST_STANDBY: begin
                if (i_start_req)
                    w_state_n = ST_PLAYING;
            end
            ST_PLAYING, ST_POWER: begin
                w_score_n = (w_score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : w_score_sum[SCORE_W-1:0];
                w_dots_n  = (w_dots_sum >= {1'b0, DOTS_MAX}) ? DOTS_MAX : w_dots_sum[8:0];
                if (r_state == ST_POWER)
                    w_respawn_n = w_rise;

                // Edge priority: collision, then win, then pellet (re)load, then expiry.
                if (r_state == ST_PLAYING && |i_ghost_hit) begin
`ifdef LIVES_EN
                    if (r_lives > 2'd1) begin
                        w_lives_n          = r_lives - 2'd1;
                        w_player_respawn_n = 1'b1;
                        w_respawn_n        = 4'hF;
                        w_state_n          = ST_STANDBY;
                    end else begin
                        w_lives_n = 2'd0;
                        w_state_n = ST_GAMEOVER;
                    end
`else
                    w_state_n = ST_GAMEOVER;
`endif
                    w_power_n = 8'd0;
                end else if (w_dots_n == DOTS_MAX) begin
                    w_state_n = ST_WIN;
                    w_power_n = 8'd0;
                end else if (i_big_dot_eaten) begin
                    w_state_n = ST_POWER;
                    w_power_n = 8'(POWER_TICKS);
                end else if (r_state == ST_POWER && i_tick) begin
                    if (r_power <= 8'd1) begin
                        w_power_n = 8'd0;
                        w_state_n = ST_PLAYING;
                    end else begin
                        w_power_n = r_power - 8'd1;
                    end
                end
            end
            default: begin
                w_power_n = 8'd0;
            end
        endcase

        w_freeze_n = !(w_state_n == ST_PLAYING || w_state_n == ST_POWER);
    end

    always_ff @(posedge clk_25MHz or negedge reset) begin
        if (!reset) begin
            r_state          <= ST_STANDBY;
            r_score          <= '0;
            r_dots           <= 9'd0;
            r_power          <= 8'd0;
            r_respawn        <= 4'd0;
            r_freeze         <= 1'b1;
            r_ghost_hit_d    <= 4'd0;
            r_lives          <= 2'd3;
            r_player_respawn <= 1'b0;
        end else begin
            r_state          <= w_state_n;
            r_score          <= w_score_n;
            r_dots           <= w_dots_n;
            r_power          <= w_power_n;
            r_respawn        <= w_respawn_n;
            r_freeze         <= w_freeze_n;
            r_ghost_hit_d    <= i_ghost_hit;
            r_lives          <= w_lives_n;
            r_player_respawn <= w_player_respawn_n;
        end
    end

    assign o_game_state      = r_state;
    assign o_freeze          = r_freeze;
    assign o_ghost_respawn   = r_respawn;
    assign o_score           = r_score;
    assign o_dots_eaten      = r_dots;
    assign o_power_remaining = r_power;
`ifdef LIVES_EN
    assign o_lives           = r_lives;
    assign o_player_respawn  = r_player_respawn;
`else
    logic w_unused;
    assign w_unused = &{1'b0, r_lives, r_player_respawn, w_lives_n, w_player_respawn_n};
`endif

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller: state flow, power countdown, ghost edges, saturation, terminal states.
module tb_game_flow_controller;

    logic        clk_25MHz = 1'b0;
    logic        reset;
    logic        i_tick, i_start_req, i_dot_eaten, i_big_dot_eaten;
    logic [3:0]  i_ghost_hit;
    logic [2:0]  o_game_state;
    logic        o_freeze;
    logic [3:0]  o_ghost_respawn;
    logic [19:0] o_score;
    logic [8:0]  o_dots_eaten;
    logic [7:0]  o_power_remaining;
`ifdef LIVES_EN
    logic [1:0]  o_lives;
    logic        o_player_respawn;
`endif

    int n_cmp = 0;
    int n_err = 0;

    game_flow_controller dut (
        .clk_25MHz         (clk_25MHz),
        .reset             (reset),
        .i_tick            (i_tick),
        .i_start_req       (i_start_req),
        .i_dot_eaten       (i_dot_eaten),
        .i_big_dot_eaten   (i_big_dot_eaten),
        .i_ghost_hit       (i_ghost_hit),
        .o_game_state      (o_game_state),
        .o_freeze          (o_freeze),
        .o_ghost_respawn   (o_ghost_respawn),
        .o_score           (o_score),
        .o_dots_eaten      (o_dots_eaten),
        .o_power_remaining (o_power_remaining)
`ifdef LIVES_EN
        ,
        .o_lives           (o_lives),
        .o_player_respawn  (o_player_respawn)
`endif
    );

    always #20 clk_25MHz = ~clk_25MHz;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk_25MHz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input int st, input int frz, input int sc,
                          input int dots, input int pwr, input int rsp);
        chk({tag, ".state"},   32'(o_game_state),      32'(st));
        chk({tag, ".freeze"},  32'(o_freeze),          32'(frz));
        chk({tag, ".score"},   32'(o_score),           32'(sc));
        chk({tag, ".dots"},    32'(o_dots_eaten),      32'(dots));
        chk({tag, ".power"},   32'(o_power_remaining), 32'(pwr));
        chk({tag, ".respawn"}, 32'(o_ghost_respawn),   32'(rsp));
    endtask

    task automatic clr();
        i_tick = 0; i_start_req = 0; i_dot_eaten = 0; i_big_dot_eaten = 0; i_ghost_hit = 4'd0;
    endtask

    initial begin
        reset = 1'b0;
        clr();
        cyc(); cyc();
        chk_st("reset", 0, 1, 0, 0, 0, 0);
`ifdef LIVES_EN
        chk("reset.lives", 32'(o_lives), 32'd3);
`endif
        reset = 1'b1;

        // STANDBY ignores everything but start_req
        i_dot_eaten = 1; i_big_dot_eaten = 1; i_ghost_hit = 4'hF; i_tick = 1;
        cyc(); clr(); cyc();
        chk_st("standby_ignore", 0, 1, 0, 0, 0, 0);

        i_start_req = 1; cyc(); i_start_req = 0;
        chk_st("start", 1, 0, 0, 0, 0, 0);
        i_start_req = 1; cyc(); cyc(); i_start_req = 0;
        chk_st("start_in_play", 1, 0, 0, 0, 0, 0);

        i_dot_eaten = 1; i_big_dot_eaten = 1; cyc(); clr();
        chk_st("both_dots", 2, 0, 60, 2, 40, 0);

        for (int i = 1; i <= 19; i++) begin
            i_tick = 1; cyc(); i_tick = 0;
            chk("pwr_count", 32'(o_power_remaining), 32'(40 - i));
            cyc();
        end

        // reload wins over a same-cycle tick
        i_tick = 1; i_big_dot_eaten = 1; cyc(); clr();
        chk_st("reload", 2, 0, 110, 3, 40, 0);

        for (int i = 1; i <= 39; i++) begin
            i_tick = 1; cyc(); i_tick = 0;
            chk("pwr_count2", 32'(o_power_remaining), 32'(40 - i));
            chk("pwr_state2", 32'(o_game_state), 32'd2);
            cyc();
        end
        i_tick = 1; cyc(); i_tick = 0;
        chk_st("expire", 1, 0, 110, 3, 0, 0);

        i_big_dot_eaten = 1; cyc(); clr();
        chk_st("power2", 2, 0, 160, 4, 40, 0);

        // held ghost contact scores once
        i_ghost_hit = 4'b0101; cyc();
        chk_st("ghost_rise", 2, 0, 560, 4, 40, 4'b0101);
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk("ghost_held.respawn", 32'(o_ghost_respawn), 32'd0);
            chk("ghost_held.score", 32'(o_score), 32'd560);
        end
        i_ghost_hit = 4'd0; cyc();
        chk_st("ghost_release", 2, 0, 560, 4, 40, 0);

        i_ghost_hit = 4'hF; cyc(); i_ghost_hit = 4'd0;
        chk_st("ghost4", 2, 0, 1360, 4, 40, 4'hF);

        for (int i = 0; i < 40; i++) begin
            i_tick = 1; cyc(); i_tick = 0; cyc();
        end
        chk_st("expire2", 1, 0, 1360, 4, 0, 0);

`ifdef LIVES_EN
        for (int k = 0; k < 2; k++) begin
            i_ghost_hit = 4'b0001; cyc(); i_ghost_hit = 4'd0;
            chk_st("life_lost", 0, 1, 1360, 4, 0, 4'hF);
            chk("life_lost.lives", 32'(o_lives), 32'(2 - k));
            chk("life_lost.prsp", 32'(o_player_respawn), 32'd1);
            i_start_req = 1; cyc(); i_start_req = 0;
            chk("life_restart.prsp", 32'(o_player_respawn), 32'd0);
            chk("life_restart.state", 32'(o_game_state), 32'd1);
        end
`endif

        i_dot_eaten = 1;
        repeat (235) cyc();
        i_dot_eaten = 0;
        chk_st("dots239", 1, 0, 3710, 239, 0, 0);

        // collision beats win on the same edge; the dot still counts
        i_dot_eaten = 1; i_ghost_hit = 4'b0100; cyc(); clr();
        chk_st("gameover", 3, 1, 3720, 240, 0, 0);
`ifdef LIVES_EN
        chk("gameover.lives", 32'(o_lives), 32'd0);
`endif
        i_start_req = 1; i_dot_eaten = 1; i_big_dot_eaten = 1; i_ghost_hit = 4'hF; i_tick = 1;
        cyc(); cyc(); clr(); cyc();
        chk_st("gameover_hold", 3, 1, 3720, 240, 0, 0);

        reset = 1'b0; cyc(); reset = 1'b1;
        chk_st("reset2", 0, 1, 0, 0, 0, 0);

        i_start_req = 1; cyc(); i_start_req = 0;
        i_big_dot_eaten = 1; cyc(); clr();
        chk_st("power3", 2, 0, 50, 1, 40, 0);

        for (int n = 1; n <= 1250; n++) begin
            i_ghost_hit = 4'hF; cyc(); i_ghost_hit = 4'd0;
            if (n == 1249)
                chk("score_near_max", 32'(o_score), 32'd999250);
            cyc();
        end
        chk("score_sat", 32'(o_score), 32'd999999);
        i_ghost_hit = 4'hF; cyc(); i_ghost_hit = 4'd0;
        chk_st("score_sat_hold", 2, 0, 999999, 1, 40, 4'hF);

        // asynchronous reset in the middle of POWER
        #5 reset = 1'b0;
        #1 chk_st("async_reset", 0, 1, 0, 0, 0, 0);
`ifdef LIVES_EN
        chk("async_reset.lives", 32'(o_lives), 32'd3);
`endif
        cyc(); reset = 1'b1;

        i_start_req = 1; cyc(); i_start_req = 0;
        i_dot_eaten = 1;
        repeat (239) cyc();
        i_dot_eaten = 0;
        chk_st("win_pre", 1, 0, 2390, 239, 0, 0);

        // dot count saturates at the limit; win beats power entry
        i_dot_eaten = 1; i_big_dot_eaten = 1; cyc(); clr();
        chk_st("win", 4, 1, 2450, 240, 0, 0);
        i_ghost_hit = 4'hF; i_start_req = 1; i_dot_eaten = 1; i_tick = 1;
        cyc(); cyc(); clr(); cyc();
        chk_st("win_hold", 4, 1, 2450, 240, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
